// File: rtl/sram_mem_ctrl_if.sv
// MEM-stage request channel into the SRAM controller: request, store data,
// load result and the ready/freeze handshake.
interface sram_mem_ctrl_if;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;

  modport master (output rd_en, wr_en, address, write_data,
                  input  read_data, ready);
  modport slave  (input  rd_en, wr_en, address, write_data,
                  output read_data, ready);
endinterface

// File: rtl/sram_mem_ctrl.sv
// 32-bit MEM-stage access to an external 16-bit asynchronous SRAM as two
// half-word transfers with WAIT_CYCLES wait states each. Define
// SRAM_READ_CACHE_EN to add a one-entry read buffer.
module sram_mem_ctrl #(
  parameter int          WAIT_CYCLES = 5,
  parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
  input  logic             clk,
  input  logic             rst,
  sram_mem_ctrl_if.slave   bus,
  inout  wire  [15:0]      SRAM_DQ,
  output logic [17:0]      SRAM_ADDR,
  output logic             SRAM_WE_N,
  output logic             SRAM_OE_N,
  output logic             SRAM_CE_N,
  output logic             SRAM_UB_N,
  output logic             SRAM_LB_N
);

  localparam int CNT_W = $clog2(WAIT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             op_wr;
  logic [16:0]      idx;
  logic [15:0]      wdata_hi;
  logic [31:0]      read_data_q;
  logic             dq_oe;
  logic [15:0]      dq_out;

  logic [16:0] req_idx;
  logic        req;
  logic        last;
  logic        rd_hit;
  logic [31:0] hit_data;

  // Offset wraps modulo 2^32; the word index is byte offset bits [18:2].
  assign req_idx = 17'((bus.address - BASE_ADDR) >> 2);
  assign req     = bus.rd_en | bus.wr_en;
  assign last    = (cnt == CNT_LAST);

  assign SRAM_DQ       = dq_oe ? dq_out : 16'bz;
  assign bus.read_data = read_data_q;
  assign bus.ready     = (state == DONE) || (state == IDLE && !bus.rd_en && !bus.wr_en);

`ifdef SRAM_READ_CACHE_EN
  logic        buf_valid;
  logic [16:0] buf_idx;
  logic [31:0] buf_data;

  assign rd_hit   = buf_valid && (buf_idx == req_idx) && !bus.wr_en;
  assign hit_data = buf_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_valid <= 1'b0;
      buf_idx   <= '0;
      buf_data  <= '0;
    end else if (state == IDLE && bus.wr_en && buf_valid && buf_idx == req_idx) begin
      buf_data <= bus.write_data;
    end else if (state == HIGH && last && !op_wr) begin
      buf_valid <= 1'b1;
      buf_idx   <= idx;
      buf_data  <= {SRAM_DQ, read_data_q[15:0]};
    end
  end
`else
  assign rd_hit   = 1'b0;
  assign hit_data = '0;
`endif

  // NOTE: every register here uses <= so each branch sees pre-edge values of
  // state, cnt and the latched request, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      op_wr       <= 1'b0;
      idx         <= '0;
      wdata_hi    <= '0;
      read_data_q <= '0;
      dq_oe       <= 1'b0;
      dq_out      <= '0;
      SRAM_ADDR   <= '0;
      SRAM_WE_N   <= 1'b1;
      SRAM_OE_N   <= 1'b1;
      SRAM_CE_N   <= 1'b1;
      SRAM_UB_N   <= 1'b1;
      SRAM_LB_N   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            op_wr    <= bus.wr_en;
            idx      <= req_idx;
            wdata_hi <= bus.write_data[31:16];
            cnt      <= '0;
            if (rd_hit) begin
              read_data_q <= hit_data;
              state       <= DONE;
            end else begin
              // Bus outputs are set up here so the first LOW cycle already
              // presents a stable address, control and write data.
              state     <= LOW;
              SRAM_ADDR <= {req_idx, 1'b0};
              SRAM_CE_N <= 1'b0;
              SRAM_UB_N <= 1'b0;
              SRAM_LB_N <= 1'b0;
              SRAM_WE_N <= ~bus.wr_en;
              SRAM_OE_N <= bus.wr_en;
              dq_oe     <= bus.wr_en;
              dq_out    <= bus.write_data[15:0];
            end
          end
        end
        LOW: begin
          if (last) begin
            cnt       <= '0;
            state     <= HIGH;
            SRAM_ADDR <= {idx, 1'b1};
            dq_out    <= wdata_hi;
            if (!op_wr) read_data_q[15:0] <= SRAM_DQ;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HIGH: begin
          if (last) begin
            cnt       <= '0;
            state     <= DONE;
            SRAM_CE_N <= 1'b1;
            SRAM_UB_N <= 1'b1;
            SRAM_LB_N <= 1'b1;
            SRAM_WE_N <= 1'b1;
            SRAM_OE_N <= 1'b1;
            dq_oe     <= 1'b0;
            if (!op_wr) read_data_q[31:16] <= SRAM_DQ;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Directed bench for sram_mem_ctrl: table of full transactions against a
// behavioural SRAM, plus reset-abort and read-buffer sequences.
module tb_sram_mem_ctrl;

  localparam int W = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  wire  [15:0] sram_dq;
  logic [17:0] sram_addr;
  logic        sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n;

  int checks   = 0;
  int failures = 0;

  sram_mem_ctrl_if bus ();

  sram_mem_ctrl #(.WAIT_CYCLES(W), .BASE_ADDR(32'd1024)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .SRAM_DQ   (sram_dq),
    .SRAM_ADDR (sram_addr),
    .SRAM_WE_N (sram_we_n),
    .SRAM_OE_N (sram_oe_n),
    .SRAM_CE_N (sram_ce_n),
    .SRAM_UB_N (sram_ub_n),
    .SRAM_LB_N (sram_lb_n)
  );

  always #5 clk = ~clk;

  // Behavioural asynchronous SRAM.
  logic [15:0] mem [0:262143];
  logic        model_drv;
  assign model_drv = !sram_ce_n && !sram_oe_n && sram_we_n;
  assign sram_dq   = model_drv ? mem[sram_addr] : 16'bz;
  always @(posedge clk) if (!sram_ce_n && !sram_we_n) mem[sram_addr] <= sram_dq;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [17:0] exp_alo;
    logic [17:0] exp_ahi;
    logic [15:0] exp_dqlo;
    logic [15:0] exp_dqhi;
    int          exp_we;
    int          exp_oe;
    logic [31:0] exp_rdata;
  } vec_t;

  // Results of one observed transaction.
  int          t_rdy, t_we, t_oe, t_ce, t_ublb;
  logic [17:0] t_a1, t_aw, t_aw1, t_a2w;
  logic [15:0] t_dq1, t_dqw1;
  logic [31:0] t_rdata;

  task automatic run_txn(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd);
    int cyc;
    t_rdy = -1; t_we = 0; t_oe = 0; t_ce = 0; t_ublb = 0;
    t_a1 = '0; t_aw = '0; t_aw1 = '0; t_a2w = '0; t_dq1 = '0; t_dqw1 = '0; t_rdata = '0;
    @(posedge clk); #1;
    bus.rd_en = rd; bus.wr_en = wr; bus.address = a; bus.write_data = wd;
    cyc = 0;
    while (cyc < 40) begin
      @(negedge clk);
      if (!sram_we_n) t_we++;
      if (!sram_oe_n) t_oe++;
      if (!sram_ce_n) t_ce++;
      if (!sram_ce_n && (sram_ub_n || sram_lb_n)) t_ublb++;
      if (cyc == 1)     begin t_a1  = sram_addr; t_dq1  = sram_dq; end
      if (cyc == W)       t_aw  = sram_addr;
      if (cyc == W + 1) begin t_aw1 = sram_addr; t_dqw1 = sram_dq; end
      if (cyc == 2 * W)   t_a2w = sram_addr;
      if (bus.ready) begin
        t_rdy   = cyc;
        t_rdata = bus.read_data;
        break;
      end
      @(posedge clk); #1;
      cyc++;
    end
    if (t_rdy < 0) check("ready_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    bus.rd_en = 1'b0; bus.wr_en = 1'b0;
  endtask

  localparam int NV = 9;
  vec_t vecs [NV];

  initial begin
    vecs[0] = '{1'b0, 1'b1, 32'd1032,    32'hDEADBEEF, 18'h00004, 18'h00005, 16'hBEEF, 16'hDEAD, 10, 0,  32'h00000000};
    vecs[1] = '{1'b1, 1'b0, 32'd1032,    32'h0,        18'h00004, 18'h00005, 16'hBEEF, 16'hDEAD, 0,  10, 32'hDEADBEEF};
    vecs[2] = '{1'b1, 1'b1, 32'd1024,    32'h0BADF00D, 18'h00000, 18'h00001, 16'hF00D, 16'h0BAD, 10, 0,  32'hDEADBEEF};
    vecs[3] = '{1'b0, 1'b1, 32'd1020,    32'hCAFE1234, 18'h3FFFE, 18'h3FFFF, 16'h1234, 16'hCAFE, 10, 0,  32'hDEADBEEF};
    vecs[4] = '{1'b1, 1'b0, 32'd1024,    32'h0,        18'h00000, 18'h00001, 16'hF00D, 16'h0BAD, 0,  10, 32'h0BADF00D};
    vecs[5] = '{1'b1, 1'b0, 32'd1020,    32'h0,        18'h3FFFE, 18'h3FFFF, 16'h1234, 16'hCAFE, 0,  10, 32'hCAFE1234};
    vecs[6] = '{1'b1, 1'b0, 32'd1035,    32'h0,        18'h00004, 18'h00005, 16'hBEEF, 16'hDEAD, 0,  10, 32'hDEADBEEF};
    vecs[7] = '{1'b0, 1'b1, 32'h00040400, 32'h5A5AA5A5, 18'h20000, 18'h20001, 16'hA5A5, 16'h5A5A, 10, 0,  32'hDEADBEEF};
    vecs[8] = '{1'b1, 1'b0, 32'h00040400, 32'h0,        18'h20000, 18'h20001, 16'hA5A5, 16'h5A5A, 0,  10, 32'h5A5AA5A5};

    bus.rd_en = 1'b0; bus.wr_en = 1'b0; bus.address = '0; bus.write_data = '0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_ready",     32'(bus.ready),     32'd1);
    check("reset_read_data", bus.read_data,      32'd0);
    check("reset_ce_n",      32'(sram_ce_n),     32'd1);
    check("reset_we_n",      32'(sram_we_n),     32'd1);
    check("reset_oe_n",      32'(sram_oe_n),     32'd1);
    check("reset_addr",      32'(sram_addr),     32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    for (int i = 0; i < NV; i++) begin
      run_txn(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
      check($sformatf("v%0d_ready_cycle", i), 32'(t_rdy),  32'(2 * W + 1));
      check($sformatf("v%0d_addr_c1", i),     32'(t_a1),   32'(vecs[i].exp_alo));
      check($sformatf("v%0d_addr_cW", i),     32'(t_aw),   32'(vecs[i].exp_alo));
      check($sformatf("v%0d_addr_cW1", i),    32'(t_aw1),  32'(vecs[i].exp_ahi));
      check($sformatf("v%0d_addr_c2W", i),    32'(t_a2w),  32'(vecs[i].exp_ahi));
      check($sformatf("v%0d_dq_lo", i),       32'(t_dq1),  32'(vecs[i].exp_dqlo));
      check($sformatf("v%0d_dq_hi", i),       32'(t_dqw1), 32'(vecs[i].exp_dqhi));
      check($sformatf("v%0d_we_cycles", i),   32'(t_we),   32'(vecs[i].exp_we));
      check($sformatf("v%0d_oe_cycles", i),   32'(t_oe),   32'(vecs[i].exp_oe));
      check($sformatf("v%0d_ce_cycles", i),   32'(t_ce),   32'(2 * W));
      check($sformatf("v%0d_lanes", i),       32'(t_ublb), 32'd0);
      check($sformatf("v%0d_read_data", i),   t_rdata,     vecs[i].exp_rdata);
    end

    // Reset in the middle of a write's LOW phase.
    @(posedge clk); #1;
    bus.wr_en = 1'b1; bus.address = 32'd1032; bus.write_data = 32'h11112222;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("abort_in_low_ce_n", 32'(sram_ce_n), 32'd0);
    check("abort_in_low_we_n", 32'(sram_we_n), 32'd0);
    rst = 1'b0; bus.wr_en = 1'b0;
    @(negedge clk);
    check("abort_ce_n",      32'(sram_ce_n),  32'd1);
    check("abort_we_n",      32'(sram_we_n),  32'd1);
    check("abort_oe_n",      32'(sram_oe_n),  32'd1);
    check("abort_read_data", bus.read_data,   32'd0);
    check("abort_ready",     32'(bus.ready),  32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("abort_idle_ready", 32'(bus.ready), 32'd1);

`ifdef SRAM_READ_CACHE_EN
    run_txn(1'b0, 1'b1, 32'd1032, 32'hDEADBEEF);
    check("c_wr_ready_cycle", 32'(t_rdy), 32'(2 * W + 1));
    run_txn(1'b1, 1'b0, 32'd1032, 32'h0);
    check("c_miss_ready_cycle", 32'(t_rdy),  32'(2 * W + 1));
    check("c_miss_read_data",   t_rdata,     32'hDEADBEEF);
    run_txn(1'b1, 1'b0, 32'd1032, 32'h0);
    check("c_hit_ready_cycle",  32'(t_rdy),  32'd1);
    check("c_hit_ce_cycles",    32'(t_ce),   32'd0);
    check("c_hit_read_data",    t_rdata,     32'hDEADBEEF);
    run_txn(1'b0, 1'b1, 32'd1032, 32'h12345678);
    check("c_wrhit_ready_cycle", 32'(t_rdy), 32'(2 * W + 1));
    check("c_wrhit_we_cycles",   32'(t_we),  32'(2 * W));
    run_txn(1'b1, 1'b0, 32'd1032, 32'h0);
    check("c_hit2_ready_cycle", 32'(t_rdy),  32'd1);
    check("c_hit2_ce_cycles",   32'(t_ce),   32'd0);
    check("c_hit2_read_data",   t_rdata,     32'h12345678);
`else
    run_txn(1'b1, 1'b0, 32'd1024, 32'h0);
    check("post_abort_ready_cycle", 32'(t_rdy), 32'(2 * W + 1));
    check("post_abort_read_data",   t_rdata,    32'h0BADF00D);
    run_txn(1'b1, 1'b0, 32'd1024, 32'h0);
    check("repeat_read_ready_cycle", 32'(t_rdy), 32'(2 * W + 1));
    check("repeat_read_ce_cycles",   32'(t_ce),  32'(2 * W));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no end expected end of test");
    $fatal(1, "timeout");
  end

endmodule
